// File: rtl/tawas_ls_queued.sv
// Tawas load/store unit: pointer+offset addressing, dcs/dack bus handshake, in-order
// tracking of up to DEPTH outstanding loads. Define TAWAS_LS_SEXT_EN for sign-extended loads.
module tawas_ls_queued #(
  parameter int unsigned RW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [1:0]             req_size,
  input  logic                   req_post_inc,
  input  logic [RW-1:0]          req_ptr_reg,
  input  logic [31:0]            req_ptr,
  input  logic [4:0]             req_off,
  input  logic [RW-1:0]          req_reg,
  input  logic [31:0]            req_wdata,
  input  logic                   req_sext,
  output logic                   dcs,
  output logic                   dwr,
  output logic [31:0]            daddr,
  output logic [3:0]             dmask,
  output logic [31:0]            dout,
  input  logic                   dack,
  input  logic                   drvalid,
  input  logic [31:0]            din,
  output logic                   wb_ptr_en,
  output logic [RW-1:0]          wb_ptr_reg,
  output logic [31:0]            wb_ptr_data,
  output logic                   wb_ld_en,
  output logic [RW-1:0]          wb_ld_reg,
  output logic [31:0]            wb_ld_data,
  output logic [$clog2(DEPTH):0] ld_pending,
  output logic                   err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          accept, push, pop;
  logic [1:0]    shamt;
  logic [31:0]   aptr, inc, addr, wdata_rep;
  logic [3:0]    mask;
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [RW-1:0] q_reg  [DEPTH];
  logic [1:0]    q_size [DEPTH];
  logic [1:0]    q_lo   [DEPTH];
`ifdef TAWAS_LS_SEXT_EN
  logic          q_sext [DEPTH];
`else
  logic          unused_sext;
  assign unused_sext = req_sext;
`endif

  // A pop in this cycle does not free a slot until ld_pending updates
  assign req_ready = (!dcs || dack) && (req_wr || (ld_pending < CW'(DEPTH)));
  assign accept    = req_valid && req_ready;
  assign push      = accept && !req_wr;
  assign pop       = drvalid && (ld_pending != '0);

  // Address generation, lane mask and store replication
  always_comb begin
    shamt     = req_size[1] ? 2'd2 : req_size;
    aptr      = req_ptr & ~((32'd1 << shamt) - 32'd1);
    inc       = aptr + ({{27{req_off[4]}}, req_off} << shamt);
    addr      = req_post_inc ? aptr : inc;
    mask      = 4'hF;
    wdata_rep = req_wdata;
    case (shamt)
      2'd0: begin
        mask      = 4'b0001 << addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        mask      = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  logic [1:0]  h_size, h_lo;
  logic [7:0]  h_byte;
  logic [31:0] ld_data;

  // Right-justify the addressed lane of the head load
  always_comb begin
    h_size  = q_size[rd_ptr];
    h_lo    = q_lo[rd_ptr];
    h_byte  = din[{h_lo, 3'b000} +: 8];
    ld_data = din;
    case (h_size)
      2'd0:    ld_data = {24'd0, h_byte};
      2'd1:    ld_data = {16'd0, h_lo[1] ? din[31:16] : din[15:0]};
      default: ;
    endcase
`ifdef TAWAS_LS_SEXT_EN
    if (q_sext[rd_ptr]) begin
      case (h_size)
        2'd0:    ld_data[31:8]  = {24{h_byte[7]}};
        2'd1:    ld_data[31:16] = {16{ld_data[15]}};
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_reg[wr_ptr]  <= req_reg;
      q_size[wr_ptr] <= shamt;
      q_lo[wr_ptr]   <= addr[1:0];
`ifdef TAWAS_LS_SEXT_EN
      q_sext[wr_ptr] <= req_sext;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcs         <= 1'b0;
      dwr         <= 1'b0;
      daddr       <= '0;
      dmask       <= '0;
      dout        <= '0;
      wb_ptr_en   <= 1'b0;
      wb_ptr_reg  <= '0;
      wb_ptr_data <= '0;
      wb_ld_en    <= 1'b0;
      wb_ld_reg   <= '0;
      wb_ld_data  <= '0;
      ld_pending  <= '0;
      err         <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (accept) begin
        dcs   <= 1'b1;
        dwr   <= req_wr;
        daddr <= addr;
        dmask <= mask;
        dout  <= wdata_rep;
      end else if (dack) begin
        dcs <= 1'b0;
      end

      wb_ptr_en <= accept && req_post_inc;
      if (accept && req_post_inc) begin
        wb_ptr_reg  <= req_ptr_reg;
        wb_ptr_data <= inc;
      end

      wb_ld_en <= pop;
      if (pop) begin
        wb_ld_reg  <= q_reg[rd_ptr];
        wb_ld_data <= ld_data;
      end

      if (drvalid && (ld_pending == '0)) err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   ld_pending <= ld_pending + CW'(1);
        2'b01:   ld_pending <= ld_pending - CW'(1);
        default: ;
      endcase
    end
  end
endmodule
